tcb_sub_mem: RTL and testbench
==============================

# tcb_sub_mem

Synthesizable TCB subordinate: a byte-addressable memory that answers manager requests on the Tightly Coupled Bus with a fixed response delay and optional programmed backpressure. It is the responding end of the TCB handshake and sits wherever a manager (CPU fetch/load-store port, VIP manager) needs a real memory target in simulation or FPGA builds. It is also the golden responder when manager VIP runs against RTL instead of VIP subordinate.

## Interface
- `DLY`, 1: response delay in cycles after the transfer (0..4).
- `ADR`, 32: address width.
- `DAT`, 32: data width; `BEN`=`DAT/8` byte lanes.
- `SIZ`, 4096: memory size in bytes, power of two, ≥`BEN`.
- `BPR`, 0: backpressure; `rdy` deasserted for `BPR` cycles after each transfer.

Ports:
- `clk` in 1: clock.
- `rst` in 1: reset. One clock; reset is synchronous and active-high.
- `tcb_vld` in 1: request valid.
- `tcb_rdy` out 1: request ready.
- `tcb_wen` in 1: write enable.
- `tcb_ren` in 1: read enable.
- `tcb_ndn` in 1: endianness (0 little, 1 big).
- `tcb_adr` in `ADR`: byte address.
- `tcb_siz` in `$clog2($clog2(BEN)+1)`: log2 transfer size in bytes.
- `tcb_ben` in `BEN`: byte enables.
- `tcb_wdt` in `DAT`: write data.
- `tcb_rdt` out `DAT`: read data.
- `tcb_sts` out 2: status; bit0 misaligned, bit1 big-endian unsupported.
- `tcb_rsp` out 1: response strobe, high in the response cycle (debug/monitor aid).

## Operation
- Transfer happens in cycles with `tcb_vld & tcb_rdy`. No other cycle has any effect.
- Word index is `adr[$clog2(SIZ)-1:$clog2(BEN)]`. Upper address bits are ignored, so addresses wrap modulo `SIZ`.
- Error checks:
  - Misaligned: `adr[$clog2(BEN)-1:0]` is not a multiple of `2**siz`, giving `sts[0]=1`.
  - Big-endian: `ndn=1` gives `sts[1]=1`.
  - On any error the write is suppressed and `rdt=0`.
- Write (`wen`, no error): each lane `i` with `ben[i]=1` is updated with `wdt[8*i+:8]`. Lanes with `ben[i]=0` are untouched.
- Read (`ren`, no error): `rdt` is the full word, all lanes. Lane selection is the manager's job.
- `wen` and `ren` together in one transfer: `rdt` returns the pre-write contents (read-before-write).
- A read in the transfer following a write to the same word returns the new data.
- Backpressure counter `cnt`:
  - `rdy = (cnt==0) & ~rst`.
  - On a transfer, `cnt` loads `BPR`.
  - While `cnt>0`, `cnt` decrements by 1 per cycle.
  - With `BPR=0`, `rdy` stays high except during reset.
- Response pipeline: a shift register of `DLY` stages carries {valid, sts, rdt}.
  - Stage 1 captures the memory read.
  - `tcb_rsp`, `tcb_sts` and `tcb_rdt` are driven from the last stage.
- Outputs outside response cycles: `rdt` and `sts` hold the last response value. They are not zeroed.

## Timing
- Reset values: `tcb_rdy=0`, `tcb_rsp=0`, `tcb_sts=0`, `tcb_rdt=0`, `cnt=0`, all pipeline valids 0. Memory contents are not cleared.
- `DLY=0`: response is combinational in the transfer cycle and `tcb_rsp = tcb_vld & tcb_rdy`.
- `DLY=N≥1`: the response for a transfer in cycle `t` appears in cycle `t+N`.
- Back-to-back transfers produce back-to-back responses. The pipeline is never stalled, because TCB has no response backpressure.
- Throughput:
  - `BPR=0`: 1 transfer/cycle.
  - Otherwise: 1 transfer per `BPR+1` cycles.
- `rdy` does not depend combinationally on `vld`.
- Reset mid-operation:
  - In-flight responses are discarded.
  - `tcb_rsp=0` from the cycle after `rst` is sampled high.
  - A write transferred in the same cycle that `rst` is high is not performed, since `rdy=0`.

## Structure
- Status bit positions and the `siz` width function belong in `tcb_pkg`, next to the existing bus typedefs.
- One natural sub-module: `tcb_sub_dly`, a parameterized `DLY`-stage valid/payload delay line with synchronous clear. It is reusable by other subordinates.
- The memory is inferred as a `logic [BEN-1:0][7:0]` array of `SIZ/BEN` words.

## Test plan
- `DLY=1`, `BPR=0`: write `0x03020100` to `0x00`, `ben=4'hF`, then read `0x00`. Required: `rsp` high 1 cycle after each transfer; read `rdt=0x03020100`, `sts=0`.
- Partial write `ben=4'b0101`, `wdt=0xAABBCCDD` to `0x04` (initially `0x13121110`), then read. Required: `rdt=0x13BB11DD`.
- `DLY=2`: 8 back-to-back reads of addresses `0x00`..`0x1C`. Required: 8 consecutive `rsp` cycles starting 2 cycles after the first transfer, data in order.
- `BPR=2`: `vld` held high for 3 requests. Required: transfers in cycles `t`, `t+3`, `t+6`; `rdy` low in the two cycles after each.
- `siz=2` at `adr=0x02` with `wen`; then `ndn=1`. Required: `sts=2'b01` then `2'b10`, `rdt=0`, memory unchanged.
- Read `0x1000` with `SIZ=4096` returns the word at `0x0000`. Then assert `rst` one cycle after a `DLY=2` transfer. Required: no `rsp` for that transfer; `rdy=0` during reset; memory retained.

Source files
------------

// File: rtl/tcb_pkg.sv
// rtl/tcb_pkg.sv - shared TCB bus types, status bit positions and width helpers
package tcb_pkg;

  // Status bit positions within tcb_sts
  localparam int unsigned TCB_STS_MIS = 0;
  localparam int unsigned TCB_STS_NDN = 1;

  typedef enum logic {
    TCB_LITTLE = 1'b0,
    TCB_BIG    = 1'b1
  } tcb_endian_t;

  typedef struct packed {
    logic ndn;
    logic mis;
  } tcb_sts_t;

  // Width of the log2-size field; never narrower than one bit
  function automatic int unsigned tcb_siz_w(input int unsigned ben);
    int unsigned w;
    w = $clog2($clog2(ben) + 1);
    return (w == 0) ? 1 : w;
  endfunction

endpackage

// File: rtl/tcb_sub_dly.sv
// rtl/tcb_sub_dly.sv - DLY-stage valid/payload delay line with synchronous clear
module tcb_sub_dly #(
  parameter int unsigned DLY = 1,
  parameter int unsigned W   = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         i_vld,
  input  logic [W-1:0] i_dat,
  output logic         o_vld,
  output logic [W-1:0] o_dat
);

  generate
    if (DLY == 0) begin : g_comb
      // Payload is held between responses so the output does not drop back to zero
      logic [W-1:0] r_hold;

      always_ff @(posedge clk) begin
        if (rst) begin
          r_hold <= '0;
        end else if (i_vld) begin
          r_hold <= i_dat;
        end
      end

      assign o_vld = i_vld;
      assign o_dat = i_vld ? i_dat : r_hold;
    end else begin : g_pipe
      logic [DLY-1:0]        r_vld;
      logic [DLY-1:0][W-1:0] r_dat;

      // Stages only load payload behind a valid, so the last stage keeps the last response
      always_ff @(posedge clk) begin
        if (rst) begin
          r_vld <= '0;
          r_dat <= '0;
        end else begin
          r_vld[0] <= i_vld;
          if (i_vld) begin
            r_dat[0] <= i_dat;
          end
          for (int k = 1; k < DLY; k++) begin
            r_vld[k] <= r_vld[k-1];
            if (r_vld[k-1]) begin
              r_dat[k] <= r_dat[k-1];
            end
          end
        end
      end

      assign o_vld = r_vld[DLY-1];
      assign o_dat = r_dat[DLY-1];
    end
  endgenerate

endmodule

// File: rtl/tcb_sub_mem.sv
// rtl/tcb_sub_mem.sv - TCB subordinate memory with fixed response delay and programmed backpressure
module tcb_sub_mem
  import tcb_pkg::*;
#(
  parameter int unsigned DLY = 1,
  parameter int unsigned ADR = 32,
  parameter int unsigned DAT = 32,
  parameter int unsigned BEN = DAT/8,
  parameter int unsigned SIZ = 4096,
  parameter int unsigned BPR = 0
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      tcb_vld,
  output logic                      tcb_rdy,
  input  logic                      tcb_wen,
  input  logic                      tcb_ren,
  input  logic                      tcb_ndn,
  input  logic [ADR-1:0]            tcb_adr,
  input  logic [tcb_siz_w(BEN)-1:0] tcb_siz,
  input  logic [BEN-1:0]            tcb_ben,
  input  logic [DAT-1:0]            tcb_wdt,
  output logic [DAT-1:0]            tcb_rdt,
  output logic [1:0]                tcb_sts,
  output logic                      tcb_rsp
);

  localparam int unsigned AW    = $clog2(SIZ);
  localparam int unsigned OW    = $clog2(BEN);
  localparam int unsigned IW    = (AW > OW) ? (AW - OW) : 1;
  localparam int unsigned WORDS = SIZ / BEN;
  localparam int unsigned CW    = (BPR > 0) ? $clog2(BPR + 1) : 1;
  localparam int unsigned PW    = 2 + DAT;

  logic [BEN-1:0][7:0] r_mem [WORDS];
  logic [CW-1:0]       r_cnt;

  logic           w_xfer;
  logic [ADR-1:0] w_mask;
  logic           w_mis;
  tcb_sts_t       w_sts;
  logic           w_ok;
  logic [IW-1:0]  w_idx;
  logic [DAT-1:0] w_rdt;
  logic [PW-1:0]  w_pay_in;
  logic [PW-1:0]  w_pay_out;

  assign tcb_rdy = (r_cnt == '0) & ~rst;
  assign w_xfer  = tcb_vld & tcb_rdy;

  // Offset bits below the transfer size must be zero; the mask never reaches past the word
  assign w_mask    = ((ADR'(1) << tcb_siz) - ADR'(1)) & ADR'(BEN - 1);
  assign w_mis     = |(tcb_adr & w_mask);
  assign w_sts.mis = w_mis;
  assign w_sts.ndn = tcb_ndn;
  assign w_ok      = ~(w_sts.mis | w_sts.ndn);

  // Upper address bits are dropped, so the memory aliases modulo SIZ
  assign w_idx = IW'(tcb_adr >> OW);

  // Asynchronous read sees the contents before this cycle's write
  assign w_rdt = (tcb_ren & w_ok) ? r_mem[w_idx] : '0;

  always_ff @(posedge clk) begin
    if (w_xfer & tcb_wen & w_ok) begin
      for (int i = 0; i < BEN; i++) begin
        if (tcb_ben[i]) begin
          r_mem[w_idx][i] <= tcb_wdt[8*i +: 8];
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (w_xfer) begin
      r_cnt <= CW'(BPR);
    end else if (r_cnt != '0) begin
      r_cnt <= r_cnt - CW'(1);
    end
  end

  assign w_pay_in = {w_sts, w_rdt};

  tcb_sub_dly #(
    .DLY (DLY),
    .W   (PW)
  ) u_dly (
    .clk   (clk),
    .rst   (rst),
    .i_vld (w_xfer),
    .i_dat (w_pay_in),
    .o_vld (tcb_rsp),
    .o_dat (w_pay_out)
  );

  assign tcb_sts = w_pay_out[DAT +: 2];
  assign tcb_rdt = w_pay_out[DAT-1:0];

endmodule

// File: tb/tb_tcb_sub_mem.sv
// tb/tb_tcb_sub_mem.sv - self-checking bench for tcb_sub_mem across delay/backpressure variants
module tb_tcb_sub_mem;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        vld [3];
  logic        wen [3];
  logic        ren [3];
  logic        ndn [3];
  logic [31:0] adr [3];
  logic [1:0]  siz [3];
  logic [3:0]  ben [3];
  logic [31:0] wdt [3];
  logic        rdy [3];
  logic        rsp [3];
  logic [31:0] rdt [3];
  logic [1:0]  sts [3];

  tcb_sub_mem #(.DLY(1), .ADR(32), .DAT(32), .SIZ(4096), .BPR(0)) u_d1 (
    .clk(clk), .rst(rst), .tcb_vld(vld[0]), .tcb_rdy(rdy[0]), .tcb_wen(wen[0]), .tcb_ren(ren[0]),
    .tcb_ndn(ndn[0]), .tcb_adr(adr[0]), .tcb_siz(siz[0]), .tcb_ben(ben[0]), .tcb_wdt(wdt[0]),
    .tcb_rdt(rdt[0]), .tcb_sts(sts[0]), .tcb_rsp(rsp[0]));

  tcb_sub_mem #(.DLY(2), .ADR(32), .DAT(32), .SIZ(4096), .BPR(0)) u_d2 (
    .clk(clk), .rst(rst), .tcb_vld(vld[1]), .tcb_rdy(rdy[1]), .tcb_wen(wen[1]), .tcb_ren(ren[1]),
    .tcb_ndn(ndn[1]), .tcb_adr(adr[1]), .tcb_siz(siz[1]), .tcb_ben(ben[1]), .tcb_wdt(wdt[1]),
    .tcb_rdt(rdt[1]), .tcb_sts(sts[1]), .tcb_rsp(rsp[1]));

  tcb_sub_mem #(.DLY(1), .ADR(32), .DAT(32), .SIZ(4096), .BPR(2)) u_bp (
    .clk(clk), .rst(rst), .tcb_vld(vld[2]), .tcb_rdy(rdy[2]), .tcb_wen(wen[2]), .tcb_ren(ren[2]),
    .tcb_ndn(ndn[2]), .tcb_adr(adr[2]), .tcb_siz(siz[2]), .tcb_ben(ben[2]), .tcb_wdt(wdt[2]),
    .tcb_rdt(rdt[2]), .tcb_sts(sts[2]), .tcb_rsp(rsp[2]));

  // Reference model: word array per instance plus a time-indexed response schedule
  logic [31:0] m_mem [3][1024];
  int          last_x [3];
  bit          sv [3][8];
  logic [1:0]  ss [3][8];
  logic [31:0] sd [3][8];
  logic [31:0] l_rdt [3];
  logic [1:0]  l_sts [3];
  bit          xf [3];
  logic        c_rsp [3];
  logic [31:0] c_rdt [3];
  logic [1:0]  c_sts [3];
  bit          h_rsp [3][4096];
  bit          h_rdy [3][4096];
  logic [31:0] h_rdt [3][4096];
  int          cyc;
  bit          armed;
  int          n_cmp;
  int          n_bad;

  typedef struct {
    logic        wen;
    logic        ren;
    logic        ndn;
    logic [31:0] adr;
    logic [1:0]  siz;
    logic [3:0]  ben;
    logic [31:0] wdt;
    logic [1:0]  e_sts;
    logic [31:0] e_rdt;
  } vec_t;

  vec_t tbl [14];

  function automatic int dly_of(input int d);
    return (d == 1) ? 2 : 1;
  endfunction

  function automatic int bpr_of(input int d);
    return (d == 2) ? 2 : 0;
  endfunction

  function automatic logic [31:0] pat(input int w);
    logic [31:0] p;
    for (int k = 0; k < 4; k++) p[8*k +: 8] = 8'(w * 16 + k);
    return p;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s cyc=%0d: got %h required %h", nm, cyc, act, exp);
    end
  endtask

  task automatic model_cycle();
    for (int d = 0; d < 3; d++) begin
      bit          r_exp;
      bit          x;
      logic [1:0]  e;
      logic [31:0] rd;
      int          wi;
      int          sl;
      int          off;
      r_exp = !rst && ((cyc - last_x[d]) > bpr_of(d));
      if (armed) chk($sformatf("rdy%0d", d), 32'(rdy[d]), 32'(r_exp));
      x = r_exp && (vld[d] === 1'b1);
      xf[d] = x;
      if (x) begin
        off  = int'(adr[d][1:0]);
        e[0] = (off % (1 << siz[d])) != 0;
        e[1] = ndn[d];
        wi   = int'(adr[d][11:2]);
        rd   = (ren[d] && e == 2'b00) ? m_mem[d][wi] : 32'h0;
        if (wen[d] && e == 2'b00) begin
          for (int k = 0; k < 4; k++)
            if (ben[d][k]) m_mem[d][wi][8*k +: 8] = wdt[d][8*k +: 8];
        end
        sl = (cyc + dly_of(d)) % 8;
        sv[d][sl] = 1'b1;
        ss[d][sl] = e;
        sd[d][sl] = rd;
        last_x[d] = cyc;
      end
      sl = cyc % 8;
      if (armed) begin
        if (sv[d][sl]) begin
          chk($sformatf("rsp%0d", d), 32'(rsp[d]), 32'd1);
          l_rdt[d] = sd[d][sl];
          l_sts[d] = ss[d][sl];
        end else begin
          chk($sformatf("rsp%0d", d), 32'(rsp[d]), 32'd0);
        end
        chk($sformatf("rdt%0d", d), rdt[d], l_rdt[d]);
        chk($sformatf("sts%0d", d), 32'(sts[d]), 32'(l_sts[d]));
      end
      sv[d][sl] = 1'b0;
      c_rsp[d] = rsp[d];
      c_rdt[d] = rdt[d];
      c_sts[d] = sts[d];
      if (cyc < 4096) begin
        h_rsp[cyc % 4096][0] = 1'b0;
        h_rsp[d][cyc] = (rsp[d] === 1'b1);
        h_rdy[d][cyc] = (rdy[d] === 1'b1);
        h_rdt[d][cyc] = rdt[d];
      end
      if (rst) begin
        for (int k = 0; k < 8; k++) sv[d][k] = 1'b0;
        l_rdt[d]  = 32'h0;
        l_sts[d]  = 2'b00;
        last_x[d] = -100;
      end
    end
    if (rst) armed = 1'b1;
    cyc++;
  endtask

  task automatic step();
    @(negedge clk);
    model_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic xfer(input int d, input logic w, input logic r, input logic n, input logic [31:0] a,
                      input logic [1:0] s, input logic [3:0] b, input logic [31:0] dat);
    int t;
    vld[d] = 1'b1; wen[d] = w; ren[d] = r; ndn[d] = n;
    adr[d] = a; siz[d] = s; ben[d] = b; wdt[d] = dat;
    t = 0;
    do begin
      step();
      t++;
    end while (!xf[d] && t < 20);
    chk($sformatf("xfer_done%0d", d), 32'(xf[d]), 32'd1);
    vld[d] = 1'b0;
  endtask

  initial begin
    int tx [3];
    int nx;
    int t0;
    logic [31:0] rv;

    n_cmp = 0; n_bad = 0; cyc = 0; armed = 1'b0;
    rst = 1'b1;
    for (int d = 0; d < 3; d++) begin
      vld[d] = 1'b0; wen[d] = 1'b0; ren[d] = 1'b0; ndn[d] = 1'b0;
      adr[d] = '0; siz[d] = 2'd2; ben[d] = 4'hF; wdt[d] = '0;
      last_x[d] = -100; l_rdt[d] = '0; l_sts[d] = '0;
      for (int k = 0; k < 8; k++) sv[d][k] = 1'b0;
      for (int k = 0; k < 1024; k++) m_mem[d][k] = 'x;
    end

    //              wen   ren   ndn   adr           siz   ben      wdt           sts    rdt
    tbl[0]  = '{1'b1, 1'b0, 1'b0, 32'h0000_0000, 2'd2, 4'hF,    32'h0302_0100, 2'b00, 32'h0000_0000};
    tbl[1]  = '{1'b0, 1'b1, 1'b0, 32'h0000_0000, 2'd2, 4'hF,    32'h0,         2'b00, 32'h0302_0100};
    tbl[2]  = '{1'b1, 1'b0, 1'b0, 32'h0000_0004, 2'd2, 4'b0101, 32'hAABB_CCDD, 2'b00, 32'h0000_0000};
    tbl[3]  = '{1'b0, 1'b1, 1'b0, 32'h0000_0004, 2'd2, 4'hF,    32'h0,         2'b00, 32'h13BB_11DD};
    tbl[4]  = '{1'b1, 1'b1, 1'b0, 32'h0000_0002, 2'd2, 4'hF,    32'hFFFF_FFFF, 2'b01, 32'h0000_0000};
    tbl[5]  = '{1'b1, 1'b1, 1'b1, 32'h0000_0000, 2'd2, 4'hF,    32'hFFFF_FFFF, 2'b10, 32'h0000_0000};
    tbl[6]  = '{1'b0, 1'b1, 1'b0, 32'h0000_0000, 2'd2, 4'hF,    32'h0,         2'b00, 32'h0302_0100};
    tbl[7]  = '{1'b0, 1'b1, 1'b0, 32'h0000_1000, 2'd2, 4'hF,    32'h0,         2'b00, 32'h0302_0100};
    tbl[8]  = '{1'b1, 1'b1, 1'b0, 32'h0000_0008, 2'd2, 4'hF,    32'hDEAD_BEEF, 2'b00, 32'h2322_2120};
    tbl[9]  = '{1'b0, 1'b1, 1'b0, 32'h0000_0008, 2'd2, 4'hF,    32'h0,         2'b00, 32'hDEAD_BEEF};
    tbl[10] = '{1'b0, 1'b1, 1'b0, 32'h0000_000B, 2'd1, 4'hF,    32'h0,         2'b01, 32'h0000_0000};
    tbl[11] = '{1'b0, 1'b1, 1'b0, 32'h0000_000A, 2'd1, 4'hF,    32'h0,         2'b00, 32'hDEAD_BEEF};
    tbl[12] = '{1'b0, 1'b1, 1'b1, 32'h0000_000C, 2'd0, 4'hF,    32'h0,         2'b10, 32'h0000_0000};
    tbl[13] = '{1'b0, 1'b1, 1'b1, 32'h0000_0001, 2'd2, 4'hF,    32'h0,         2'b11, 32'h0000_0000};

    repeat (3) step();
    rst = 1'b0;

    for (int d = 0; d < 3; d++)
      for (int w = 0; w < 16; w++)
        xfer(d, 1'b1, 1'b0, 1'b0, 32'(w * 4), 2'd2, 4'hF, pat(w));

    for (int i = 0; i < 14; i++) begin
      xfer(0, tbl[i].wen, tbl[i].ren, tbl[i].ndn, tbl[i].adr, tbl[i].siz, tbl[i].ben, tbl[i].wdt);
      step();
      chk($sformatf("tbl%0d_rsp", i), 32'(c_rsp[0]), 32'd1);
      chk($sformatf("tbl%0d_rdt", i), c_rdt[0], tbl[i].e_rdt);
      chk($sformatf("tbl%0d_sts", i), 32'(c_sts[0]), 32'(tbl[i].e_sts));
    end

    // Eight back-to-back reads through the two-stage pipeline
    vld[1] = 1'b1; wen[1] = 1'b0; ren[1] = 1'b1; ndn[1] = 1'b0; siz[1] = 2'd2; ben[1] = 4'hF;
    t0 = cyc;
    for (int i = 0; i < 8; i++) begin
      adr[1] = 32'(i * 4);
      step();
      chk("b2b_xfer", 32'(xf[1]), 32'd1);
    end
    vld[1] = 1'b0;
    repeat (4) step();
    chk("b2b_pre", 32'(h_rsp[1][t0+1]), 32'd0);
    for (int i = 0; i < 8; i++) begin
      chk($sformatf("b2b_rsp%0d", i), 32'(h_rsp[1][t0+2+i]), 32'd1);
      chk($sformatf("b2b_rdt%0d", i), h_rdt[1][t0+2+i], pat(i));
    end
    chk("b2b_post", 32'(h_rsp[1][t0+10]), 32'd0);

    // Write then read of the same word in consecutive transfers
    vld[1] = 1'b1; wen[1] = 1'b1; ren[1] = 1'b0; adr[1] = 32'h14; wdt[1] = 32'h5A5A_5A5A;
    t0 = cyc;
    step();
    wen[1] = 1'b0; ren[1] = 1'b1;
    step();
    vld[1] = 1'b0;
    repeat (3) step();
    chk("raw_rdt", h_rdt[1][t0+3], 32'h5A5A_5A5A);

    // Backpressure spacing with vld held high
    vld[2] = 1'b1; wen[2] = 1'b0; ren[2] = 1'b1; ndn[2] = 1'b0; adr[2] = 32'h0; siz[2] = 2'd2;
    nx = 0;
    for (int k = 0; k < 20 && nx < 3; k++) begin
      step();
      if (xf[2]) begin
        tx[nx] = cyc - 1;
        nx++;
      end
    end
    vld[2] = 1'b0;
    chk("bp_count", 32'(nx), 32'd3);
    if (nx == 3) begin
      chk("bp_gap0", 32'(tx[1] - tx[0]), 32'd3);
      chk("bp_gap1", 32'(tx[2] - tx[1]), 32'd3);
      chk("bp_rdy1", 32'(h_rdy[2][tx[0]+1]), 32'd0);
      chk("bp_rdy2", 32'(h_rdy[2][tx[0]+2]), 32'd0);
      chk("bp_rdy3", 32'(h_rdy[2][tx[0]+3]), 32'd1);
    end
    step();

    // Reset one cycle after a delayed transfer, with a write attempted during reset
    xfer(1, 1'b0, 1'b1, 1'b0, 32'h4, 2'd2, 4'hF, 32'h0);
    t0 = cyc - 1;
    rst = 1'b1;
    vld[0] = 1'b1; wen[0] = 1'b1; ren[0] = 1'b0; ndn[0] = 1'b0; adr[0] = 32'h30; siz[0] = 2'd2;
    ben[0] = 4'hF; wdt[0] = 32'hFFFF_FFFF;
    step();
    rst = 1'b0;
    vld[0] = 1'b0;
    step();
    step();
    chk("rst_rdy1", 32'(h_rdy[1][t0+1]), 32'd0);
    chk("rst_rdy0", 32'(h_rdy[0][t0+1]), 32'd0);
    chk("rst_norsp", 32'(h_rsp[1][t0+2]), 32'd0);
    xfer(0, 1'b0, 1'b1, 1'b0, 32'h30, 2'd2, 4'hF, 32'h0);
    step();
    chk("rst_nowrite", c_rdt[0], pat(12));
    xfer(1, 1'b0, 1'b1, 1'b0, 32'h0, 2'd2, 4'hF, 32'h0);
    step();
    step();
    chk("rst_keep_rsp", 32'(c_rsp[1]), 32'd1);
    chk("rst_keep_rdt", c_rdt[1], pat(0));

    // Randomized traffic against the model
    for (int n = 0; n < 600; n++) begin
      for (int d = 0; d < 3; d++) begin
        rv     = $urandom();
        vld[d] = ($urandom_range(0, 9) < 7);
        wen[d] = 1'($urandom_range(0, 1));
        ren[d] = 1'($urandom_range(0, 1));
        ndn[d] = ($urandom_range(0, 7) == 0);
        siz[d] = 2'($urandom_range(0, 2));
        ben[d] = 4'($urandom_range(0, 15));
        wdt[d] = $urandom();
        adr[d] = {rv[31:12], 6'b0, 4'($urandom_range(0, 15)), 2'($urandom_range(0, 3))};
      end
      rst = ($urandom_range(0, 99) == 0);
      step();
    end
    rst = 1'b0;
    for (int d = 0; d < 3; d++) vld[d] = 1'b0;
    repeat (6) step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
